fir_coeff_loader: RTL

- Upstream feeder for the 64-tap FIR's coefficient chain.
- Accepts a byte stream from the host link (valid/ready) and assembles little-endian 32-bit signed Q-format words: 64 tap coefficients plus one output-scale word.
- Buffers one complete frame, then streams the words in order on a single-cycle-per-word shift-enable bus into the filter's coefficient shift register. Word 0 lands in tap 0; the scale word lands in the last slot.
- Runs entirely on clk_coeff.

---
 rtl/fir_coeff_loader.sv | 131 +++++++++++++
 1 files changed

// File: rtl/fir_coeff_loader.sv
// Purpose : collects a 65-word little-endian coefficient frame from a byte
//           stream and shifts it word by word into the FIR coefficient chain.
// Latency : first word shifted one cycle after the last byte is accepted;
//           65 shift cycles, then load_done one cycle later.
// Backpressure: byte_ready is low for the whole streaming phase, and the
//           source holds its byte until then.
//
// Ports:
//   clk_coeff, reset   clock and synchronous active-high reset
//   frame_start        restarts frame collection (ignored while streaming)
//   byte_data/_valid   host byte stream; byte_ready is the accept handshake
//   coef_data          coefficient word, zero whenever coef_shift is low
//   coef_shift         filter chain advances one slot when high
//   load_done          one-cycle pulse after the last word has been shifted
//   coef_loaded        the filter chain holds a complete frame
module fir_coeff_loader #(
  parameter int NUM_WORDS = 65,
  parameter int WORD_W    = 32,
  parameter int IDX_W     = 7
) (
  input  logic              clk_coeff,
  input  logic              reset,
  input  logic              frame_start,
  input  logic [7:0]        byte_data,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic [WORD_W-1:0] coef_data,
  output logic              coef_shift,
  output logic              load_done,
  output logic              coef_loaded
);

  typedef enum logic {COLLECT, STREAM} state_t;

  state_t              state;
  logic [1:0]          byte_cnt;
  logic [IDX_W-1:0]    word_idx;
  logic [WORD_W-9:0]   asm_q;     // lower three bytes of the word in progress
  logic [WORD_W-1:0]   mem [NUM_WORDS];

  logic                accept;
  logic [1:0]          cnt_eff;
  logic [IDX_W-1:0]    idx_eff;
  logic                word_wr;
  logic                last_word;
  logic [WORD_W-1:0]   wr_word;

  // frame_start clears the counters in the same cycle, so a byte arriving
  // with it is treated as byte 0 of word 0.
  always_comb begin
    accept    = (state == COLLECT) && byte_valid && byte_ready;
    cnt_eff   = frame_start ? 2'd0 : byte_cnt;
    idx_eff   = frame_start ? '0 : word_idx;
    word_wr   = accept && (cnt_eff == 2'd3);
    last_word = (idx_eff == IDX_W'(NUM_WORDS - 1));
    wr_word   = {byte_data, asm_q};
  end

  // Frame buffer: not cleared by reset, only the control state is.
  always_ff @(posedge clk_coeff) begin
    if (word_wr && !reset) begin
      mem[idx_eff] <= wr_word;
    end
  end

  always_ff @(posedge clk_coeff) begin
    if (reset) begin
      state       <= COLLECT;
      byte_cnt    <= 2'd0;
      word_idx    <= '0;
      asm_q       <= '0;
      coef_data   <= '0;
      coef_shift  <= 1'b0;
      load_done   <= 1'b0;
      coef_loaded <= 1'b0;
      byte_ready  <= 1'b1;
    end else begin
      load_done <= 1'b0;
      case (state)
        COLLECT: begin
          if (frame_start) begin
            byte_cnt    <= 2'd0;
            word_idx    <= '0;
            coef_loaded <= 1'b0;
          end
          if (accept) begin
            case (cnt_eff)
              2'd0:    asm_q[7:0]   <= byte_data;
              2'd1:    asm_q[15:8]  <= byte_data;
              2'd2:    asm_q[23:16] <= byte_data;
              default: ;
            endcase
            if (cnt_eff == 2'd3) begin
              byte_cnt <= 2'd0;
              if (last_word) begin
                state      <= STREAM;
                word_idx   <= '0;
                byte_ready <= 1'b0;
              end else begin
                word_idx <= idx_eff + IDX_W'(1);
              end
            end else begin
              byte_cnt <= cnt_eff + 2'd1;
            end
          end
        end

        STREAM: begin
          // word_idx walks 0..NUM_WORDS-1 while shifting; reaching
          // NUM_WORDS means the whole frame is in the chain.
          if (word_idx == IDX_W'(NUM_WORDS)) begin
            coef_shift  <= 1'b0;
            coef_data   <= '0;
            load_done   <= 1'b1;
            coef_loaded <= 1'b1;
            byte_ready  <= 1'b1;
            word_idx    <= '0;
            state       <= COLLECT;
          end else begin
            coef_shift <= 1'b1;
            coef_data  <= mem[word_idx];
            word_idx   <= word_idx + IDX_W'(1);
          end
        end

        default: state <= COLLECT;
      endcase
    end
  end

endmodule
